// File: rtl/window_compositor.sv
// window_compositor: composites NUM_WIN movable RGB565 windows onto the VGA raster with 3-cycle latency.
// Define WINDOW_COMPOSITOR_BORDER_EN to paint BORDER_COLOR on the edge of the winning window.
module window_compositor #(
    parameter int          NUM_WIN      = 2,
    parameter int          WIN_W        = 174,
    parameter int          WIN_H        = 144,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          STEP         = 1,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter logic [15:0] BORDER_COLOR = 16'hFFE0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic [16*NUM_WIN-1:0]   win_pix,
    input  logic                    btn_x,
    input  logic                    btn_y,
    input  logic [1:0]              win_sel,
    output logic [10*NUM_WIN-1:0]   x_addr,
    output logic [10*NUM_WIN-1:0]   y_addr,
    output logic [NUM_WIN-1:0]      hit,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b,
    output logic [9:0]              sel_off_x,
    output logic [9:0]              sel_off_y
);
    localparam logic [10:0] MAX_X = 11'(H_ACTIVE - WIN_W);
    localparam logic [10:0] MAX_Y = 11'(V_ACTIVE - WIN_H);

    if (NUM_WIN < 1 || NUM_WIN > 4 || NUM_WIN * WIN_W > H_ACTIVE) begin : g_cfg_err
        $error("window_compositor: NUM_WIN must be 1..4 and NUM_WIN*WIN_W <= H_ACTIVE");
    end

    logic [9:0]            off_x_q [NUM_WIN];
    logic [9:0]            off_x_d [NUM_WIN];
    logic [9:0]            off_y_q [NUM_WIN];
    logic [9:0]            off_y_d [NUM_WIN];
    logic [10:0]           nxt_x   [NUM_WIN];
    logic [10:0]           nxt_y   [NUM_WIN];
    logic                  btn_x_q, btn_y_q;
    logic                  edge_x, edge_y;
    logic [NUM_WIN-1:0]    hit_q, hit_d, hit2_q;
    logic [10*NUM_WIN-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
    logic [15:0]           pix;
    logic [23:0]           rgb_q, rgb_d;

    assign edge_x = btn_x & ~btn_x_q;
    assign edge_y = btn_y & ~btn_y_q;

    // Offset stepping; selects beyond NUM_WIN match no window, so edges are dropped.
    always_comb begin
        sel_off_x = '0;
        sel_off_y = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            nxt_x[i]   = {1'b0, off_x_q[i]} + 11'(STEP);
            nxt_y[i]   = {1'b0, off_y_q[i]} + 11'(STEP);
            off_x_d[i] = (edge_x && win_sel == 2'(i)) ? ((nxt_x[i] > MAX_X) ? '0 : nxt_x[i][9:0]) : off_x_q[i];
            off_y_d[i] = (edge_y && win_sel == 2'(i)) ? ((nxt_y[i] > MAX_Y) ? '0 : nxt_y[i][9:0]) : off_y_q[i];
            sel_off_x  = (win_sel == 2'(i)) ? off_x_q[i] : sel_off_x;
            sel_off_y  = (win_sel == 2'(i)) ? off_y_q[i] : sel_off_y;
        end
    end

    always_comb begin
        hit_d    = '0;
        x_addr_d = '0;
        y_addr_d = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit_d[i] = ({1'b0, pixel_x} >= {1'b0, off_x_q[i]}) &&
                       ({1'b0, pixel_x} <  {1'b0, off_x_q[i]} + 11'(WIN_W)) &&
                       ({1'b0, pixel_y} >= {1'b0, off_y_q[i]}) &&
                       ({1'b0, pixel_y} <  {1'b0, off_y_q[i]} + 11'(WIN_H));
            x_addr_d[10*i +: 10] = pixel_x - off_x_q[i];
            y_addr_d[10*i +: 10] = pixel_y - off_y_q[i];
        end
    end

`ifdef WINDOW_COMPOSITOR_BORDER_EN
    logic [10*NUM_WIN-1:0] x_addr2_q, y_addr2_q;
    logic                  brd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_addr2_q <= '0;
            y_addr2_q <= '0;
        end else begin
            x_addr2_q <= x_addr_q;
            y_addr2_q <= y_addr_q;
        end
    end
`endif

    // Lowest index wins, so iterate downward letting later (lower) hits override.
    always_comb begin
        pix = BG_COLOR;
        for (int i = NUM_WIN - 1; i >= 0; i--) pix = hit2_q[i] ? win_pix[16*i +: 16] : pix;
`ifdef WINDOW_COMPOSITOR_BORDER_EN
        brd = 1'b0;
        for (int i = NUM_WIN - 1; i >= 0; i--)
            brd = hit2_q[i] ? (x_addr2_q[10*i +: 10] == 10'd0 || x_addr2_q[10*i +: 10] == 10'(WIN_W - 1) ||
                               y_addr2_q[10*i +: 10] == 10'd0 || y_addr2_q[10*i +: 10] == 10'(WIN_H - 1)) : brd;
        pix = brd ? BORDER_COLOR : pix;
`endif
        rgb_d = {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                off_x_q[i] <= 10'(i * WIN_W);
                off_y_q[i] <= '0;
            end
            btn_x_q  <= 1'b0;
            btn_y_q  <= 1'b0;
            hit_q    <= '0;
            hit2_q   <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            rgb_q    <= '0;
        end else begin
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            btn_x_q  <= btn_x;
            btn_y_q  <= btn_y;
            hit_q    <= hit_d;
            hit2_q   <= hit_q;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hit    = hit_q;
    assign x_addr = x_addr_q;
    assign y_addr = y_addr_q;
    assign vga_r  = rgb_q[23:16];
    assign vga_g  = rgb_q[15:8];
    assign vga_b  = rgb_q[7:0];
endmodule
